// File: rtl/axi_slave_pkg.sv
// Shared types for the AXI slave memory: response/burst codes and FSM states.
package axi_slave_pkg;

  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_e;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  localparam int BYTES = 4;

  // Encodings are ordered so that the numerically larger code is the more severe one.
  function automatic resp_e resp_max(input resp_e a, input resp_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_slave_mem_ram.sv
// 1W/1R synchronous RAM, one byte-wide array per lane, registered read port.
module axi_slave_mem_ram
  import axi_slave_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [BYTES-1:0]     wstrb,
  input  logic [AW-1:0]        waddr,
  input  logic [8*BYTES-1:0]   wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [8*BYTES-1:0]   rdata
);

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_reg;

    // Same-address read and write in one cycle returns the old byte.
    always_ff @(posedge clk) begin
      if (we && wstrb[gi]) mem[waddr] <= wdata[8*gi +: 8];
      if (re) q_reg <= mem[raddr];
    end

    assign rdata[8*gi +: 8] = q_reg;
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4-style slave memory: independent write (AW/W/B) and read (AR/R) engines
// around a byte-enabled block RAM, with SLVERR/DECERR reporting.
module axi_slave_mem
  import axi_slave_pkg::*;
#(
  parameter int                DEPTH     = 256,
  parameter int                ADDR_W    = 32,
  parameter int                ID_W      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [1:0]        AWBURST,
  input  logic [ID_W-1:0]   AWID,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  output logic [ID_W-1:0]   BID,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [1:0]        ARBURST,
  input  logic [ID_W-1:0]   ARID,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic [ID_W-1:0]   RID
);

  localparam int                AW   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(BYTES * DEPTH);

  function automatic resp_e beat_resp(input logic [ADDR_W-1:0] addr, input burst_e burst);
    resp_e r;
    if (addr < BASE_ADDR || (addr - BASE_ADDR) >= SPAN) r = DECERR;
    else if (burst == WRAP || burst == RSVD)            r = SLVERR;
    else                                                 r = OKAY;
    return r;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return AW'((addr - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr, input burst_e burst);
    return (burst == INCR) ? addr + ADDR_W'(BYTES) : addr;
  endfunction

  // Write engine state
  wr_state_e         wr_state_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [3:0]        wr_len_reg;
  logic [4:0]        wr_cnt_reg;
  burst_e            wr_burst_reg;
  logic [ID_W-1:0]   wr_id_reg;
  resp_e             wr_resp_reg;
  logic              awready_reg, wready_reg, bvalid_reg;

  // Read engine state
  rd_state_e         rd_state_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [3:0]        rd_len_reg, rd_cnt_reg;
  burst_e            rd_burst_reg;
  logic [ID_W-1:0]   rd_id_reg;
  resp_e             rresp_reg;
  logic              arready_reg, rvalid_reg, rlast_reg;

  resp_e             wr_beat_resp;
  logic              wr_cnt_err, ram_we;
  logic              ar_hs, r_hs, rd_load, rd_load_last;
  logic [ADDR_W-1:0] rd_load_addr;
  burst_e            rd_load_burst;
  logic [31:0]       ram_rdata;

  always_comb begin
    wr_beat_resp = beat_resp(wr_addr_reg, wr_burst_reg);
    // Wrong beat count: WLAST off the expected beat, or missing on/after it.
    wr_cnt_err   = WLAST ? (wr_cnt_reg != {1'b0, wr_len_reg}) : (wr_cnt_reg >= {1'b0, wr_len_reg});
    ram_we       = wready_reg && WVALID && (wr_beat_resp == OKAY);

    // The RAM is read whenever a new beat must appear on R next cycle.
    ar_hs         = ARVALID && arready_reg;
    r_hs          = rvalid_reg && RREADY;
    rd_load       = ar_hs || (r_hs && !rlast_reg);
    rd_load_addr  = ar_hs ? ARADDR : next_addr(rd_addr_reg, rd_burst_reg);
    rd_load_burst = ar_hs ? burst_e'(ARBURST) : rd_burst_reg;
    rd_load_last  = ar_hs ? (ARLEN == 4'd0) : (rd_cnt_reg + 4'd1 == rd_len_reg);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state_reg <= W_IDLE;
      wr_addr_reg  <= '0;
      wr_len_reg   <= '0;
      wr_cnt_reg   <= '0;
      wr_burst_reg <= INCR;
      wr_id_reg    <= '0;
      wr_resp_reg  <= OKAY;
      awready_reg  <= 1'b1;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
    end else begin
      case (wr_state_reg)
        W_IDLE: if (AWVALID) begin
          wr_addr_reg  <= AWADDR;
          wr_len_reg   <= AWLEN;
          wr_burst_reg <= burst_e'(AWBURST);
          wr_id_reg    <= AWID;
          wr_cnt_reg   <= '0;
          wr_resp_reg  <= OKAY;
          awready_reg  <= 1'b0;
          wready_reg   <= 1'b1;
          wr_state_reg <= W_DATA;
        end
        W_DATA: if (WVALID) begin
          wr_addr_reg <= next_addr(wr_addr_reg, wr_burst_reg);
          wr_cnt_reg  <= wr_cnt_reg + 5'd1;
          wr_resp_reg <= resp_max(wr_resp_reg, resp_max(wr_beat_resp, wr_cnt_err ? SLVERR : OKAY));
          if (WLAST) begin
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b1;
            wr_state_reg <= W_RESP;
          end
        end
        W_RESP: if (BREADY) begin
          bvalid_reg   <= 1'b0;
          awready_reg  <= 1'b1;
          wr_state_reg <= W_IDLE;
        end
        default: wr_state_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state_reg <= R_IDLE;
      rd_addr_reg  <= '0;
      rd_len_reg   <= '0;
      rd_cnt_reg   <= '0;
      rd_burst_reg <= INCR;
      rd_id_reg    <= '0;
      rresp_reg    <= OKAY;
      arready_reg  <= 1'b1;
      rvalid_reg   <= 1'b0;
      rlast_reg    <= 1'b0;
    end else begin
      if (ar_hs) begin
        rd_len_reg   <= ARLEN;
        rd_burst_reg <= burst_e'(ARBURST);
        rd_id_reg    <= ARID;
        rd_cnt_reg   <= '0;
        arready_reg  <= 1'b0;
        rd_state_reg <= R_DATA;
      end else if (r_hs && rlast_reg) begin
        rvalid_reg   <= 1'b0;
        rlast_reg    <= 1'b0;
        rresp_reg    <= OKAY;
        arready_reg  <= 1'b1;
        rd_state_reg <= R_IDLE;
      end else if (r_hs) begin
        rd_cnt_reg <= rd_cnt_reg + 4'd1;
      end
      if (rd_load) begin
        rd_addr_reg <= rd_load_addr;
        rvalid_reg  <= 1'b1;
        rlast_reg   <= rd_load_last;
        rresp_reg   <= beat_resp(rd_load_addr, rd_load_burst);
      end
    end
  end

  axi_slave_mem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (ACLK),
    .we    (ram_we),
    .wstrb (WSTRB),
    .waddr (word_idx(wr_addr_reg)),
    .wdata (WDATA),
    .re    (rd_load),
    .raddr (word_idx(rd_load_addr)),
    .rdata (ram_rdata)
  );

  assign AWREADY = awready_reg;
  assign WREADY  = wready_reg;
  assign BVALID  = bvalid_reg;
  assign BRESP   = wr_resp_reg;
  assign BID     = wr_id_reg;
  assign ARREADY = arready_reg;
  assign RVALID  = rvalid_reg;
  assign RRESP   = rresp_reg;
  assign RLAST   = rlast_reg;
  assign RID     = rd_id_reg;
  // Erroring beats and idle cycles drive zero data.
  assign RDATA   = (rvalid_reg && rresp_reg == OKAY) ? ram_rdata : '0;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed + randomized bench for axi_slave_mem against a word-array reference model.
module tb_axi_slave_mem;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int TOUT   = 200;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b1;
  logic              AWVALID = 1'b0, AWREADY;
  logic [ADDR_W-1:0] AWADDR = '0;
  logic [3:0]        AWLEN = '0;
  logic [1:0]        AWBURST = '0;
  logic [ID_W-1:0]   AWID = '0;
  logic              WVALID = 1'b0, WREADY;
  logic [31:0]       WDATA = '0;
  logic [3:0]        WSTRB = '0;
  logic              WLAST = 1'b0;
  logic              BVALID, BREADY = 1'b0;
  logic [1:0]        BRESP;
  logic [ID_W-1:0]   BID;
  logic              ARVALID = 1'b0, ARREADY;
  logic [ADDR_W-1:0] ARADDR = '0;
  logic [3:0]        ARLEN = '0;
  logic [1:0]        ARBURST = '0;
  logic [ID_W-1:0]   ARID = '0;
  logic              RVALID, RREADY = 1'b0;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic [ID_W-1:0]   RID;

  axi_slave_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ID_W(ID_W), .BASE_ADDR(32'h0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARID(ARID),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RID(RID)
  );

  always #5 ACLK = ~ACLK;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd [32];
  logic [3:0]  ws [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules: byte address of beat i, and the response that beat earns.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
    return (burst == 2'b01) ? a + 32'(4 * i) : a;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a, input logic [1:0] burst);
    if (a >= 32'(4 * DEPTH)) return 2'b11;
    if (burst[1])             return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_beat(input logic [31:0] a, input logic [1:0] burst, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a / 4) % DEPTH;
    if (model_resp(a, burst) == 2'b00)
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic aw_send(input string tag, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    AWADDR = addr; AWLEN = len; AWBURST = burst; AWID = id; AWVALID = 1'b1;
    while (AWREADY !== 1'b1 && n < TOUT) begin @(posedge ACLK); #1; n++; end
    if (n >= TOUT) check({tag, "_aw_timeout"}, 32'(AWREADY), 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  task automatic w_beat(input string tag, input logic [31:0] d, input logic [3:0] s, input logic last);
    int n = 0;
    WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
    while (WREADY !== 1'b1 && n < TOUT) begin @(posedge ACLK); #1; n++; end
    if (n >= TOUT) check({tag, "_w_timeout"}, 32'(WREADY), 32'd1);
    @(posedge ACLK); #1;
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [3:0] id, input int nbeats);
    logic [1:0] exp_resp;
    logic [31:0] a;
    int n = 0;
    exp_resp = (nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
    aw_send(tag, addr, len, burst, id);
    for (int i = 0; i < nbeats; i++) begin
      a = beat_addr(addr, burst, i);
      exp_resp = worse(exp_resp, model_resp(a, burst));
      w_beat(tag, wd[i], ws[i], i == nbeats - 1);
      model_beat(a, burst, wd[i], ws[i]);
    end
    while (BVALID !== 1'b1 && n < TOUT) begin @(posedge ACLK); #1; n++; end
    check({tag, "_bvalid"}, 32'(BVALID), 32'd1);
    check({tag, "_bresp"}, 32'(BRESP), 32'(exp_resp));
    check({tag, "_bid"}, 32'(BID), 32'(id));
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check({tag, "_b_done"}, 32'(BVALID), 32'd0);
    $display("write %s addr=%h len=%0d burst=%0d beats=%0d bresp=%0d", tag, addr, len, burst, nbeats, BRESP);
  endtask

  task automatic axi_read(input string tag, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [3:0] id,
                          input int stall_beat, input int stall_cycles);
    logic [31:0] a, d;
    logic [1:0]  r;
    int n = 0;
    ARADDR = addr; ARLEN = len; ARBURST = burst; ARID = id; ARVALID = 1'b1;
    while (ARREADY !== 1'b1 && n < TOUT) begin @(posedge ACLK); #1; n++; end
    if (n >= TOUT) check({tag, "_ar_timeout"}, 32'(ARREADY), 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    RREADY = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, burst, i);
      r = model_resp(a, burst);
      d = (r == 2'b00) ? ref_mem[int'(a / 4) % DEPTH] : 32'h0;
      if (i == stall_beat) begin
        RREADY = 1'b0;
        for (int k = 0; k < stall_cycles; k++) begin
          @(posedge ACLK); #1;
          check({tag, "_stall_rvalid"}, 32'(RVALID), 32'd1);
          check({tag, "_stall_rdata"}, RDATA, d);
        end
        RREADY = 1'b1;
      end
      check({tag, "_rvalid"}, 32'(RVALID), 32'd1);
      check({tag, "_rdata"}, RDATA, d);
      check({tag, "_rresp"}, 32'(RRESP), 32'(r));
      check({tag, "_rlast"}, 32'(RLAST), 32'(i == int'(len)));
      check({tag, "_rid"}, 32'(RID), 32'(id));
      @(posedge ACLK); #1;
    end
    RREADY = 1'b0;
    check({tag, "_r_done"}, 32'(RVALID), 32'd0);
    check({tag, "_arready"}, 32'(ARREADY), 32'd1);
    $display("read  %s addr=%h len=%0d burst=%0d stall=%0d/%0d", tag, addr, len, burst, stall_beat, stall_cycles);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 32'(AWREADY), 32'd1);
    check({tag, "_arready"}, 32'(ARREADY), 32'd1);
    check({tag, "_wready"},  32'(WREADY),  32'd0);
    check({tag, "_bvalid"},  32'(BVALID),  32'd0);
    check({tag, "_rvalid"},  32'(RVALID),  32'd0);
    check({tag, "_rlast"},   32'(RLAST),   32'd0);
    check({tag, "_bresp"},   32'(BRESP),   32'd0);
    check({tag, "_rresp"},   32'(RRESP),   32'd0);
    check({tag, "_rdata"},   RDATA,        32'd0);
    check({tag, "_bid"},     32'(BID),     32'd0);
    check({tag, "_rid"},     32'(RID),     32'd0);
  endtask

  initial begin
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    int          sel, nb;

    #2 ARESETn = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    check_reset_outputs("reset");
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // Preload every word so all later reads have a defined expectation.
    for (int k = 0; k < DEPTH / 16; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      axi_write("preload", 32'(k * 64), 4'd15, 2'b01, 4'(k), 16);
    end

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write("single", 32'h10, 4'd0, 2'b01, 4'd3, 1);
    axi_read("single", 32'h10, 4'd0, 2'b01, 4'd3, -1, 0);

    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    axi_write("incr4", 32'h20, 4'd3, 2'b01, 4'd5, 4);
    axi_read("incr4", 32'h20, 4'd3, 2'b01, 4'd6, -1, 0);

    wd[0] = 32'h11223344; ws[0] = 4'hF;
    axi_write("preload40", 32'h40, 4'd0, 2'b01, 4'd1, 1);
    wd[0] = 32'hAAAAAAAA; ws[0] = 4'h1;
    wd[1] = 32'hBBBBBBBB; ws[1] = 4'h8;
    axi_write("fixed_strb", 32'h40, 4'd1, 2'b00, 4'd2, 2);
    axi_read("fixed_strb", 32'h40, 4'd0, 2'b01, 4'd2, -1, 0);
    check("fixed_strb_const", RDATA, 32'h0);

    for (int i = 0; i < 2; i++) begin wd[i] = 32'hCAFE0000 + 32'(i); ws[i] = 4'hF; end
    axi_write("wrap_wr", 32'h80, 4'd1, 2'b10, 4'd7, 2);
    axi_read("wrap_chk", 32'h80, 4'd1, 2'b01, 4'd7, -1, 0);
    axi_read("wrap_rd", 32'h80, 4'd1, 2'b10, 4'd8, -1, 0);

    wd[0] = 32'h600DF00D; wd[1] = 32'hBAD0BAD0; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write("decerr_wr", 32'(4 * DEPTH - 4), 4'd1, 2'b01, 4'd9, 2);
    axi_read("decerr_chk", 32'(4 * DEPTH - 4), 4'd0, 2'b01, 4'd9, -1, 0);
    axi_read("decerr_rd", 32'(4 * DEPTH), 4'd0, 2'b01, 4'd10, -1, 0);
    axi_read("decerr_span", 32'(4 * DEPTH - 8), 4'd3, 2'b01, 4'd10, 2, 2);

    axi_read("stall5", 32'h20, 4'd3, 2'b01, 4'd11, 2, 5);
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write("early_wlast", 32'h60, 4'd3, 2'b01, 4'd12, 2);
    axi_write("late_wlast", 32'h70, 4'd1, 2'b01, 4'd13, 3);
    axi_read("wlast_chk", 32'h60, 4'd7, 2'b01, 4'd13, -1, 0);

    // Async reset in the middle of a 4-beat write; outputs must clear without a clock edge.
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    aw_send("rst_mid", 32'h100, 4'd3, 2'b01, 4'd14);
    for (int i = 0; i < 2; i++) begin
      w_beat("rst_mid", wd[i], ws[i], 1'b0);
      model_beat(32'h100 + 32'(4 * i), 2'b01, wd[i], ws[i]);
    end
    WDATA = wd[2]; WVALID = 1'b1;
    #2 ARESETn = 1'b0;
    WVALID = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge ACLK); @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    wd[0] = 32'h5A5A1234; ws[0] = 4'hF;
    axi_write("post_rst", 32'h200, 4'd0, 2'b01, 4'd4, 1);
    axi_read("post_rst", 32'h100, 4'd3, 2'b01, 4'd4, -1, 0);
    axi_read("post_rst2", 32'h200, 4'd0, 2'b01, 4'd4, -1, 0);

    for (int t = 0; t < 30; t++) begin
      sel   = $urandom_range(0, 9);
      burst = (sel == 0) ? 2'($urandom_range(2, 3)) : (sel < 4) ? 2'b00 : 2'b01;
      addr  = 32'($urandom_range(0, 4 * DEPTH + 32));
      len   = 4'($urandom_range(0, 15));
      sel   = $urandom_range(0, 7);
      nb    = (sel == 0 && len > 0) ? int'(len) : (sel == 1) ? int'(len) + 2 : int'(len) + 1;
      for (int i = 0; i < nb; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      axi_write("rand", addr, len, burst, 4'($urandom), nb);
      axi_read("rand", addr, len, burst, 4'($urandom), $urandom_range(0, 16), $urandom_range(1, 4));
      axi_read("rand_incr", 32'($urandom_range(0, 4 * DEPTH + 16)), 4'($urandom_range(0, 15)), 2'b01,
               4'($urandom), -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- AXI4-style slave memory responder sitting directly downstream of the NoC arbiter's slave port; consumes the AW/W/AR channels the arbiter drives and returns B/R responses.
- Word-addressed 32-bit RAM with byte strobes, INCR/FIXED bursts and independent write and read engines.
- Serves as the RTL endpoint for arbiter integration and as the reference target for the slave-side UVM agent.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two.
- ADDR_W, 32, AXI address width.
- ID_W, 4, transaction ID width.
- BASE_ADDR, 32'h0000_0000, first byte address decoded by this slave.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- AWADDR  in  ADDR_W  write start byte address.
- AWLEN  in  4  beats minus one.
- AWBURST  in  2  burst type.
- AWID  in  ID_W  write ID.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- WDATA  in  32  write data.
- WSTRB  in  4  byte enables.
- WLAST  in  1  last write beat.
- BVALID  out  1  response valid.
- BREADY  in  1  response ready.
- BRESP  out  2  write response.
- BID  out  ID_W  echoed AWID.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- ARADDR  in  ADDR_W  read start byte address.
- ARLEN  in  4  beats minus one.
- ARBURST  in  2  burst type.
- ARID  in  ID_W  read ID.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RLAST  out  1  last read beat.
- RID  out  ID_W  echoed ARID.

Behaviour:
- Reset: AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BRESP=0, RRESP=0, RDATA=0, BID=0, RID=0. Memory contents are not reset.
- Reset mid-burst: both FSMs return to IDLE immediately; no response is issued for the aborted burst.
- Write FSM has three states:
  - W_IDLE: AWREADY=1. AW handshake latches addr, len, burst and id, clears the error flag, then goes to W_DATA. WREADY rises on the next cycle.
  - W_DATA: AWREADY=0, WREADY=1. Each W handshake writes the bytes whose WSTRB bit is set, then advances the address. The state is left only on the WLAST handshake, going to W_RESP.
  - W_RESP: BVALID=1, BRESP = sticky error code. A B handshake returns the FSM to W_IDLE.
- Read FSM has two states:
  - R_IDLE: ARREADY=1. AR handshake latches addr, len, burst and id.
  - R_DATA: RVALID is asserted one cycle after the AR handshake, with registered RDATA. Each R handshake advances the beat and presents the next beat on the following cycle.
  - Gapless streaming at one beat per cycle while RREADY=1. RVALID/RDATA stay stable while RREADY=0.
  - RLAST=1 on beat ARLEN. The R handshake with RLAST returns the FSM to R_IDLE.
- Address generation:
  - Word index = (addr - BASE_ADDR)[log2(DEPTH)+1:2]; addr[1:0] is ignored.
  - INCR (2'b01): +4 per beat, with no 4KB-boundary check.
  - FIXED (2'b00): address is constant.
- Errors:
  - WRAP (2'b10) or reserved (2'b11) burst: SLVERR (2'b10) for the whole burst. No memory write; read data is 0.
  - Beat address outside [BASE_ADDR, BASE_ADDR+4*DEPTH): DECERR (2'b11) for that beat. The write is suppressed; read data is 0.
  - A write beat count not equal to AWLEN+1 (WLAST early, or no WLAST by beat AWLEN) gives SLVERR. The FSM still waits for WLAST.
  - BRESP priority: DECERR > SLVERR > OKAY, sticky across the burst. RRESP is per beat.
- Write and read to the same word in the same cycle: the read returns the old data (read-before-write).
- No outstanding transactions: one write and one read may be in flight concurrently, with no reordering.

Decomposition:
- Package axi_slave_pkg holds:
  - resp_e enum: OKAY, EXOKAY, SLVERR, DECERR.
  - burst_e enum: FIXED, INCR, WRAP, RSVD.
  - wr_state_e and rd_state_e enums.
  - Localparam BYTES=4.
- Natural sub-module: axi_slave_mem_ram, a 1W/1R synchronous RAM with byte enables and a registered read port, instantiated once.

Test Plan:
- Single write then read: AW addr 0x10, len 0, INCR, id 3, WDATA 0xDEADBEEF, WSTRB 4'hF. Expected B: BRESP 0, BID 3. AR of 0x10 returns RDATA 0xDEADBEEF, RLAST 1, RID 3.
- INCR burst: write 4 beats (len 3) at 0x20 with data 1,2,3,4. Reading 4 beats back returns 1,2,3,4, RLAST only on beat 4, with no idle cycles when RREADY is held at 1.
- Strobes and FIXED: preload 0x11223344 at 0x40, then FIXED len 1 writing 0xAAAAAAAA (WSTRB 4'h1) and 0xBBBBBBBB (WSTRB 4'h8). Read returns 0xBB2233AA.
- Errors:
  - WRAP burst write: BRESP 2'b10, memory unchanged.
  - INCR len 1 starting at the last word: BRESP 2'b11, last word written.
  - Read at 4*DEPTH: RRESP 2'b11, RDATA 0.
- Backpressure and early WLAST: hold RREADY=0 for 5 cycles mid-burst; RDATA must stay stable. A write with len 3 and WLAST on beat 2 gives BRESP 2'b10.
- Async reset: assert ARESETn=0 mid write burst. Outputs go to reset values with no ACLK edge needed. After release, a fresh transaction completes with OKAY.
